// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO. Frames are start, LSB-first data,
// optional parity and one or two stop bits. Queued frames are sent back-to-back.
module uart_tx_fifo #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD_RT    = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          tx_send,
  output logic                          tx_busy,
  output logic                          tx_done
);

  localparam int CYCLES_PER_BIT = CLK_HZ / BAUD_RT;
  localparam int CNT_W          = $clog2(CYCLES_PER_BIT);
  localparam int PTR_W          = $clog2(FIFO_DEPTH);
  localparam int CNT_PW         = PTR_W + 1;
  localparam int BIT_W          = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0]  BAUD_RELOAD = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [CNT_PW-1:0] FIFO_FULL   = CNT_PW'(FIFO_DEPTH);
  localparam logic [BIT_W-1:0]  LAST_BIT    = BIT_W'(DATA_BITS - 1);
  localparam logic              LAST_STOP   = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] mem_reg [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_reg;
  logic [PTR_W-1:0]     rd_ptr_reg;
  logic [CNT_PW-1:0]    count_reg;

  // Transmit state
  state_t               state_reg;
  logic [CNT_W-1:0]     baud_cnt_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic [BIT_W-1:0]     bit_idx_reg;
  logic                 stop_idx_reg;
  logic                 parity_reg;
  logic                 tx_send_reg;
  logic                 tx_done_reg;

  logic                 wr_en;
  logic                 pop;
  logic                 bit_end;
  logic                 stop_last;
  logic                 fifo_nonempty;
  logic [DATA_BITS-1:0] head_word;
  logic [DATA_BITS:0]   par_chain;

  assign tx_ready      = (count_reg != FIFO_FULL);
  assign fifo_count    = count_reg;
  assign tx_send       = tx_send_reg;
  assign tx_done       = tx_done_reg;
  assign tx_busy       = (state_reg != S_IDLE);

  assign wr_en         = tx_valid && tx_ready;
  assign fifo_nonempty = (count_reg != '0);
  assign bit_end       = (baud_cnt_reg == '0);
  assign stop_last     = (stop_idx_reg == LAST_STOP);
  assign head_word     = mem_reg[rd_ptr_reg];

  // Pops happen only from IDLE or at the very end of the last stop bit, and
  // only on words already counted, so a fresh write is never bypassed.
  assign pop = fifo_nonempty &&
               ((state_reg == S_IDLE) ||
                ((state_reg == S_STOP) && bit_end && stop_last));

  // Seeding the chain with 1 yields odd parity, with 0 even parity.
  assign par_chain[0] = (PARITY == 2);
  generate
    for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_parity
      assign par_chain[gi+1] = par_chain[gi] ^ head_word[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_ptr_reg] <= tx_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({wr_en, pop})
        2'b10:   count_reg <= count_reg + CNT_PW'(1);
        2'b01:   count_reg <= count_reg - CNT_PW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= S_IDLE;
      baud_cnt_reg <= '0;
      shift_reg    <= '0;
      bit_idx_reg  <= '0;
      stop_idx_reg <= 1'b0;
      parity_reg   <= 1'b0;
      tx_send_reg  <= 1'b1;
      tx_done_reg  <= 1'b0;
    end else begin
      tx_done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          tx_send_reg <= 1'b1;
          if (pop) begin
            shift_reg    <= head_word;
            parity_reg   <= par_chain[DATA_BITS];
            baud_cnt_reg <= BAUD_RELOAD;
            tx_send_reg  <= 1'b0;
            state_reg    <= S_START;
          end
        end

        S_START: begin
          if (bit_end) begin
            baud_cnt_reg <= BAUD_RELOAD;
            tx_send_reg  <= shift_reg[0];
            shift_reg    <= shift_reg >> 1;
            bit_idx_reg  <= '0;
            state_reg    <= S_DATA;
          end else begin
            baud_cnt_reg <= baud_cnt_reg - CNT_W'(1);
          end
        end

        S_DATA: begin
          if (bit_end) begin
            baud_cnt_reg <= BAUD_RELOAD;
            if (bit_idx_reg == LAST_BIT) begin
              if (PARITY != 0) begin
                tx_send_reg <= parity_reg;
                state_reg   <= S_PARITY;
              end else begin
                tx_send_reg  <= 1'b1;
                stop_idx_reg <= 1'b0;
                state_reg    <= S_STOP;
              end
            end else begin
              tx_send_reg <= shift_reg[0];
              shift_reg   <= shift_reg >> 1;
              bit_idx_reg <= bit_idx_reg + BIT_W'(1);
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg - CNT_W'(1);
          end
        end

        S_PARITY: begin
          if (bit_end) begin
            baud_cnt_reg <= BAUD_RELOAD;
            tx_send_reg  <= 1'b1;
            stop_idx_reg <= 1'b0;
            state_reg    <= S_STOP;
          end else begin
            baud_cnt_reg <= baud_cnt_reg - CNT_W'(1);
          end
        end

        S_STOP: begin
          if (bit_end) begin
            if (stop_last) begin
              tx_done_reg <= 1'b1;
              // Chain straight into the next frame when work is queued.
              if (pop) begin
                shift_reg    <= head_word;
                parity_reg   <= par_chain[DATA_BITS];
                baud_cnt_reg <= BAUD_RELOAD;
                tx_send_reg  <= 1'b0;
                state_reg    <= S_START;
              end else begin
                tx_send_reg <= 1'b1;
                state_reg   <= S_IDLE;
              end
            end else begin
              baud_cnt_reg <= BAUD_RELOAD;
              stop_idx_reg <= 1'b1;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg - CNT_W'(1);
          end
        end

        default: begin
          tx_send_reg <= 1'b1;
          state_reg   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
